// File: rtl/sample3_array_serializer.sv
// Serializes a captured array of 4-bit elements, enabled per element by a mask,
// onto a valid/ready stream in ascending index order, counting completed frames.
module sample3_array_serializer #(
  parameter bit [3:0]    param1 = 4'd5,
  parameter int unsigned param2 = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_i,
  input  logic [3:0]        arr_i  [0:param1],
  input  logic              mask_i [0:param1],
  input  logic              ready_i,
  output logic [3:0]        data_o,
  output logic [3:0]        idx_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              busy_o,
  output logic [param2-1:0] frames_o
);

  localparam int unsigned DEPTH = 32'(param1) + 32'd1;
  localparam int unsigned FW    = param2;

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [3:0]       shadow_arr_q [DEPTH];
  logic [3:0]       shadow_arr_d [DEPTH];
  logic [DEPTH-1:0] shadow_mask_q, shadow_mask_d;
  logic [3:0]       data_q, data_d;
  logic [3:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic [FW-1:0]    frames_q, frames_d;

  logic             load_ok;
  logic             xfer;
  logic [4:0]       start;
  logic             hit;
  logic             more;
  logic [3:0]       nxt_idx;
  logic [3:0]       nxt_data;

  // Select capture source and find the first enabled element at or above start;
  // 'more' reports whether any further enabled element exists beyond that one.
  always_comb begin
    load_ok       = (state_q == IDLE) && load_i;
    xfer          = valid_q && ready_i;
    start         = load_ok ? 5'd0 : ({1'b0, idx_q} + 5'd1);
    hit           = 1'b0;
    more          = 1'b0;
    nxt_idx       = 4'd0;
    nxt_data      = 4'd0;
    shadow_mask_d = shadow_mask_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      shadow_arr_d[i]  = load_ok ? arr_i[i]  : shadow_arr_q[i];
      shadow_mask_d[i] = load_ok ? mask_i[i] : shadow_mask_q[i];
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (shadow_mask_d[i] && (i >= int'(start))) begin
        if (!hit) begin
          hit      = 1'b1;
          nxt_idx  = 4'(i);
          nxt_data = shadow_arr_d[i];
        end else begin
          more = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_ok && hit) state_d = SEND;
      SEND:    if (xfer && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    frames_d = frames_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        if (load_ok) begin
          if (hit) begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            data_d  = nxt_data;
            idx_d   = nxt_idx;
            last_d  = !more;
          end else begin
            frames_d = frames_q + FW'(1);
          end
        end
      end
      SEND: begin
        if (xfer) begin
          if (last_q) begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            busy_d   = 1'b0;
            frames_d = frames_q + FW'(1);
          end else begin
            data_d = nxt_data;
            idx_d  = nxt_idx;
            last_d = !more;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) shadow_arr_q[i] <= 4'd0;
      shadow_mask_q <= '0;
      data_q        <= 4'd0;
      idx_q         <= 4'd0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
      frames_q      <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) shadow_arr_q[i] <= shadow_arr_d[i];
      shadow_mask_q <= shadow_mask_d;
      data_q        <= data_d;
      idx_q         <= idx_d;
      valid_q       <= valid_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
      frames_q      <= frames_d;
    end
  end

  assign data_o   = data_q;
  assign idx_o    = idx_q;
  assign valid_o  = valid_q;
  assign last_o   = last_q;
  assign busy_o   = busy_q;
  assign frames_o = frames_q;

endmodule

// File: tb/tb_sample3_array_serializer.sv
// Randomized self-checking bench: a queue model of the expected beats per frame
// is compared every cycle against the serializer output.
module tb_sample3_array_serializer;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] idx;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load_i;
  logic        ready_i;
  logic [3:0]  arr_i  [0:5];
  logic        mask_i [0:5];
  logic [3:0]  data_o, idx_o, data_w, idx_w;
  logic        valid_o, last_o, busy_o, valid_w, last_w, busy_w;
  logic [31:0] frames_o;
  logic [1:0]  frames_w;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_frames = 32'd0;

  sample3_array_serializer #(.param1(4'd5), .param2(32)) dut (
    .clk(clk), .rstn(rstn), .load_i(load_i), .arr_i(arr_i), .mask_i(mask_i),
    .ready_i(ready_i), .data_o(data_o), .idx_o(idx_o), .valid_o(valid_o),
    .last_o(last_o), .busy_o(busy_o), .frames_o(frames_o)
  );

  sample3_array_serializer #(.param1(4'd5), .param2(2)) dut_w (
    .clk(clk), .rstn(rstn), .load_i(load_i), .arr_i(arr_i), .mask_i(mask_i),
    .ready_i(ready_i), .data_o(data_w), .idx_o(idx_w), .valid_o(valid_w),
    .last_o(last_w), .busy_o(busy_w), .frames_o(frames_w)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [5:0][3:0] a, input logic [5:0] m);
    for (int i = 0; i < 6; i++) begin
      arr_i[i]  = a[i];
      mask_i[i] = m[i];
    end
  endtask

  // Loads one frame and follows it to completion, checking every cycle.
  task automatic drive_frame(input logic [5:0][3:0] a, input logic [5:0] m,
                             input int stall_idx, input int stall_n,
                             input bit rand_ready, input bit busy_load);
    beat_t q[$];
    beat_t b;
    int    stalls;
    int    budget;
    bit    rdy;
    for (int i = 0; i < 6; i++) begin
      if (m[i]) begin
        b.data = a[i];
        b.idx  = 4'(i);
        b.last = 1'b0;
        q.push_back(b);
      end
    end
    if (q.size() > 0) begin
      b = q.pop_back();
      b.last = 1'b1;
      q.push_back(b);
    end
    set_inputs(a, m);
    load_i  = 1'b1;
    ready_i = 1'($urandom_range(0, 1));
    step();
    load_i = 1'b0;
    stalls = stall_n;
    budget = 0;
    while (q.size() > 0 && budget < 64) begin
      budget++;
      total++;
      if ({valid_o, busy_o, data_o, idx_o, last_o} !== {2'b11, q[0].data, q[0].idx, q[0].last})
        $display("FAIL beat: got v=%b b=%b d=%0d i=%0d l=%b, expected v=1 b=1 d=%0d i=%0d l=%b",
                 valid_o, busy_o, data_o, idx_o, last_o, q[0].data, q[0].idx, q[0].last);
      else passed++;
      total++;
      if (frames_o !== exp_frames)
        $display("FAIL frames_mid: got %0d, expected %0d", frames_o, exp_frames);
      else passed++;
      set_inputs(24'($urandom), 6'($urandom) | 6'b000001);
      load_i = busy_load;
      if (int'(q[0].idx) == stall_idx && stalls > 0) begin
        rdy = 1'b0;
        stalls--;
      end else begin
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      ready_i = rdy;
      step();
      if (rdy) void'(q.pop_front());
    end
    if (q.size() > 0) begin
      total++;
      $display("FAIL frame_timeout: got %0d beats pending, expected 0", q.size());
    end
    exp_frames = exp_frames + 32'd1;
    total++;
    if ({valid_o, busy_o, last_o} !== 3'b000)
      $display("FAIL frame_end: got v=%b b=%b l=%b, expected 000", valid_o, busy_o, last_o);
    else passed++;
    total++;
    if (frames_o !== exp_frames)
      $display("FAIL frames_end: got %0d, expected %0d", frames_o, exp_frames);
    else passed++;
    total++;
    if (frames_w !== 2'(exp_frames))
      $display("FAIL frames_wrap_end: got %0d, expected %0d", frames_w, 2'(exp_frames));
    else passed++;
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn    = 1'b1;
    load_i  = 1'b0;
    ready_i = 1'b0;
    set_inputs(24'hFFFFFF, 6'h3F);
    step();
    step();
    total++;
    if ({data_o, idx_o, valid_o, last_o, busy_o, frames_o} !== 43'd0)
      $display("FAIL reset: got d=%0d i=%0d v=%b l=%b b=%b f=%0d, expected all 0",
               data_o, idx_o, valid_o, last_o, busy_o, frames_o);
    else passed++;
    rstn       = 1'b0;
    exp_frames = 32'd0;
  endtask

  task automatic test_full_frame();
    logic [5:0][3:0] a;
    for (int i = 0; i < 6; i++) a[i] = 4'(i + 1);
    drive_frame(a, 6'h3F, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_sparse();
    logic [5:0][3:0] a;
    for (int i = 0; i < 6; i++) a[i] = 4'(9 - i);
    drive_frame(a, 6'b111010, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [5:0][3:0] a;
    for (int i = 0; i < 6; i++) a[i] = 4'(i + 1);
    drive_frame(a, 6'h3F, 2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_zero_mask();
    drive_frame(24'h123456, 6'b000000, -1, 0, 1'b0, 1'b0);
    step();
    total++;
    if ({valid_o, busy_o} !== 2'b00 || frames_o !== exp_frames)
      $display("FAIL zero_mask_idle: got v=%b b=%b f=%0d, expected v=0 b=0 f=%0d",
               valid_o, busy_o, frames_o, exp_frames);
    else passed++;
  endtask

  task automatic test_load_during_busy();
    logic [5:0][3:0] a;
    for (int i = 0; i < 6; i++) a[i] = 4'(i + 1);
    drive_frame(a, 6'h3F, -1, 0, 1'b0, 1'b1);
    drive_frame(24'hABCDEF, 6'b101101, -1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0][3:0] a;
    for (int i = 0; i < 6; i++) a[i] = 4'(i + 1);
    set_inputs(a, 6'h3F);
    load_i = 1'b1;
    step();
    load_i  = 1'b0;
    ready_i = 1'b1;
    step();
    step();
    step();
    total++;
    if ({valid_o, idx_o, data_o} !== {1'b1, 4'd3, 4'd4})
      $display("FAIL pre_reset_beat: got v=%b i=%0d d=%0d, expected v=1 i=3 d=4", valid_o, idx_o, data_o);
    else passed++;
    rstn = 1'b1;
    step();
    total++;
    if ({data_o, idx_o, valid_o, last_o, busy_o, frames_o, data_w, idx_w, valid_w, last_w, busy_w, frames_w} !== 56'd0)
      $display("FAIL reset_mid_frame: got d=%0d i=%0d v=%b l=%b b=%b f=%0d fw=%0d, expected all 0",
               data_o, idx_o, valid_o, last_o, busy_o, frames_o, frames_w);
    else passed++;
    rstn       = 1'b0;
    exp_frames = 32'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({valid_o, busy_o} !== 2'b00 || frames_o !== 32'd0)
        $display("FAIL post_reset_quiet: got v=%b b=%b f=%0d, expected v=0 b=0 f=0", valid_o, busy_o, frames_o);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    int wrap_seq[5] = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      drive_frame(24'($urandom), 6'($urandom) | 6'b100000, -1, 0, 1'b1, 1'b0);
      total++;
      if (frames_w !== 2'(wrap_seq[k]))
        $display("FAIL wrap_seq[%0d]: got %0d, expected %0d", k, frames_w, wrap_seq[k]);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [5:0] m;
    for (int k = 0; k < 25; k++) begin
      m = ($urandom_range(0, 4) == 0) ? 6'b000000 : 6'($urandom);
      drive_frame(24'($urandom), m, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                  1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_sparse();
    test_backpressure();
    test_zero_mask();
    test_load_during_busy();
    test_reset_mid_frame();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
